if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer that replaces free-running PC stepping in the IF stage.
//  - Owns the PC and steps it by 4.
//  - Handshakes with the instruction ROM (ce/addr held until ack).
//  - Applies flush/branch redirects and pipeline stalls.
//  - Drives the registered IF/ID payload (if_pc, if_inst, if_valid), with a 1-entry skid buffer.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset release
//  EXC_VECTOR  32'h0000_0020  redirect target on fetch timeout (FETCH_TIMEOUT_EN only)
//  TIMEOUT     16             cycles of ce=1 without ack before abort (FETCH_TIMEOUT_EN only)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   asynchronous reset, active-low (rst==0 resets)
//  stall        in   1   downstream cannot accept; if_* must hold
//  flush        in   1   exception redirect (highest priority)
//  new_pc       in   32  flush target
//  branch_flag  in   1   branch redirect
//  branch_addr  in   32  branch target
//  rom_ce       out  1   fetch request active
//  rom_addr     out  32  fetch address; stable while rom_ce=1 until ack
//  rom_ack      in   1   data valid this cycle (sampled only when rom_ce=1)
//  rom_data     in   32  instruction word
//  if_pc        out  32  PC of if_inst
//  if_inst      out  32  fetched instruction
//  if_valid     out  1   if_pc/if_inst valid
//  fetch_err    out  1   1-cycle pulse on fetch timeout (tied 0 without macro)
// BEHAVIOUR
//  - Reset values: state=IDLE, pc_q=RESET_PC, rom_ce=0, rom_addr=RESET_PC,
//    if_pc=0, if_inst=0, if_valid=0, fetch_err=0, skid empty.
//  - Reset mid-transaction: immediate; outstanding request abandoned; late ack ignored (rom_ce=0).
//  - rom_addr = pc_q (registered); pc_q+4 wraps modulo 2^32; addresses never checked for alignment.
//  - Redirect: flush -> new_pc; else branch_flag -> branch_addr.
//    Either one clears if_valid on the next edge and applies regardless of stall.
//  - Consume: if_valid & ~stall at an edge; if nothing new is loaded, if_valid<=0.
//  - States:
//   IDLE   rom_ce=0; next edge -> REQ (one dead cycle after reset, as before).
//   REQ    rom_ce=1. On an edge:
//          - redirect & ack:   discard data; pc_q<=target; stay REQ.
//          - redirect & ~ack:  redir_q<=target; -> DRAIN.
//          - ack & ~stall:     if_*<=(pc_q,rom_data), if_valid=1; pc_q+=4; stay REQ.
//          - ack & stall & ~if_valid: load if_*; pc_q+=4; -> WAIT.
//          - ack & stall & if_valid:  skid<=(pc_q,rom_data); pc_q+=4; -> SKID.
//          - no ack: hold.
//          Zero-wait ROM (ack every cycle) -> one instruction per cycle, latency 1 edge.
//   DRAIN  rom_ce=1, rom_addr unchanged.
//          - Redirect here overwrites redir_q.
//          - On ack: discard data; pc_q<=redir_q; -> REQ.
//   WAIT   rom_ce=0. Redirect -> pc_q<=target, -> REQ. ~stall -> REQ.
//   SKID   rom_ce=0. Redirect -> drop skid, pc_q<=target, -> REQ.
//          ~stall -> if_*<=skid, if_valid=1, -> REQ.
//  - Invariants:
//    - rom_ce never drops while a request is unacked (except reset/timeout).
//    - No instruction is lost or duplicated across stall.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//   - Counter runs while rom_ce=1 & ~rom_ack; clears on ack or state change.
//   - At TIMEOUT:
//     - fetch_err=1 for one cycle.
//     - Request abandoned; rom_ce=0 for that one cycle (IDLE).
//     - pc_q<=EXC_VECTOR; if_valid<=0; skid and redir_q discarded; then REQ.
//  Not defined: no counter; fetch_err tied 0; a request waits indefinitely.
// TESTING
//  1 Reset release with ack always 1 -> rom_ce=0 one cycle; then rom_addr 0,4,8,C;
//    if_pc follows one cycle later with matching rom_data.
//  2 Ack after 3 wait cycles for addr 0x8 -> rom_addr=0x8 and rom_ce=1 held 3 cycles; if_pc=0x8 once.
//  3 stall=1 for 4 cycles while if_valid=1 and ack arrives for 0x10 -> 0x10 parked in skid;
//    if_* unchanged; after stall drops: if_pc=0x10 then 0x14 (no loss or duplicate).
//  4 branch_flag=1, branch_addr=0x100 while request for 0x20 is unacked ->
//    0x20 data discarded on ack; next rom_addr=0x100; if_valid=0 meanwhile.
//  5 flush(new_pc=0x40) and branch(0x100) same cycle -> next fetch at 0x40.
//  6 FETCH_TIMEOUT_EN, TIMEOUT=16, ack held 0 -> fetch_err pulses at cycle 16;
//    rom_ce low 1 cycle; then rom_addr=0x20. rst=0 mid-wait -> all outputs to reset values at once.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, handshakes the instruction ROM, drives the registered IF/ID payload.
// Latency: one edge from rom_ack to if_valid; a zero-wait ROM sustains one instruction per cycle.
// Backpressure: stall holds if_*; a fetch landing under stall is kept (payload or 1-entry skid), then rom_ce drops.
// Optional FETCH_TIMEOUT_EN: abandon a fetch unacked for TIMEOUT cycles, pulse fetch_err, restart at EXC_VECTOR.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_addr,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic        rom_ack,
    input  logic [31:0] rom_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        fetch_err
);

    typedef enum logic [2:0] {IDLE, REQ, DRAIN, WAIT, SKID} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q;
    logic [31:0] redir_q;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;
    logic        redirect;
    logic [31:0] target;
    logic        ack;
    logic        consume;
    logic        timeout;

    assign redirect = flush | branch_flag;
    assign target   = flush ? new_pc : branch_addr;
    assign ack      = rom_ce & rom_ack;
    assign consume  = if_valid & ~stall;
    assign rom_addr = pc_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;
    logic          waiting;

    assign waiting = rom_ce & ~rom_ack;
    assign timeout = waiting && (tmo_cnt == CW'(TIMEOUT - 1));

    // Any state change (including the abort itself) restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt   <= '0;
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= timeout;
            if (!waiting || (state_nxt != state)) tmo_cnt <= '0;
            else                                  tmo_cnt <= tmo_cnt + CW'(1);
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign timeout        = 1'b0;
    assign fetch_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = REQ;
                REQ: begin
                    if (redirect)          state_nxt = ack ? REQ : DRAIN;
                    else if (ack && stall) state_nxt = if_valid ? SKID : WAIT;
                end
                DRAIN: if (ack) state_nxt = REQ;
                WAIT:  if (redirect || !stall) state_nxt = REQ;
                SKID:  if (redirect || !stall) state_nxt = REQ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        rom_ce = (state == REQ) || (state == DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            redir_q   <= '0;
            skid_pc   <= '0;
            skid_inst <= '0;
            if_pc     <= '0;
            if_inst   <= '0;
            if_valid  <= 1'b0;
        end else if (timeout) begin
            pc_q     <= EXC_VECTOR;
            if_valid <= 1'b0;
        end else begin
            // Loads below override this clear when a new word arrives.
            if (redirect || consume) if_valid <= 1'b0;
            case (state)
                IDLE: if (redirect) pc_q <= target;
                REQ: begin
                    if (redirect) begin
                        if (ack) pc_q    <= target;
                        else     redir_q <= target;
                    end else if (ack) begin
                        pc_q <= pc_q + 32'd4;
                        if (stall && if_valid) begin
                            skid_pc   <= pc_q;
                            skid_inst <= rom_data;
                        end else begin
                            if_pc    <= pc_q;
                            if_inst  <= rom_data;
                            if_valid <= 1'b1;
                        end
                    end
                end
                // The in-flight word is for the old path; it is dropped on ack.
                DRAIN: begin
                    if (redirect) begin
                        if (ack) pc_q    <= target;
                        else     redir_q <= target;
                    end else if (ack) begin
                        pc_q <= redir_q;
                    end
                end
                WAIT: if (redirect) pc_q <= target;
                SKID: begin
                    if (redirect) begin
                        pc_q <= target;
                    end else if (!stall) begin
                        if_pc    <= skid_pc;
                        if_inst  <= skid_inst;
                        if_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
